fma_operand_unpacker: RTL and testbench

Front end of the single-precision MAC datapath. Accepts the raw IEEE-754 operands of A + B*C, along with the operation and rounding mode, over a valid/ready handshake. It unpacks and classifies each operand and delivers registered fields to the multiplier/aligner two cycles later. The class flags, effective-subtraction sign and hidden-bit mantissas it produces are exactly the fields the Rounder consumes at the far end of the pipe.

---
 rtl/fma_pkg.sv | 33 +++
 rtl/fp_classify.sv | 32 +++
 rtl/fma_operand_unpacker.sv | 133 +++++++++++++
 tb/tb_fma_operand_unpacker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared types and constants for the single-precision MAC datapath.
// Operand field widths, rounding-mode codes and the per-operand class bundle.
package fma_pkg;

   localparam int PARM_EXP   = 8;
   localparam int PARM_MANT  = 23;
   localparam int PARM_RM    = 3;
   localparam int PARM_WIDTH = PARM_EXP + PARM_MANT + 1;

   // Quiet bit of the stored fraction; clear on a NaN means signalling.
   localparam logic [PARM_MANT-1:0] PARM_MANT_NAN = 23'h400000;

   typedef enum logic [PARM_RM-1:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rounding_mode_e;

   typedef struct packed {
      logic                 sign;
      logic [PARM_EXP-1:0]  exp_raw;
      logic [PARM_EXP-1:0]  exp_eff;
      logic [PARM_MANT:0]   mant;
      logic                 den;
      logic                 zero;
      logic                 inf;
      logic                 nan;
      logic                 snan;
   } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack/classify of one raw IEEE-754 single-precision operand.
module fp_classify
   import fma_pkg::*;
(
   input  logic [PARM_WIDTH-1:0] operand,
   output fp_class_t             cls
);

   logic [PARM_EXP-1:0]  exp_field;
   logic [PARM_MANT-1:0] frac_field;
   logic                 exp_zero;
   logic                 exp_ones;
   logic                 frac_zero;

   assign exp_field  = operand[PARM_MANT +: PARM_EXP];
   assign frac_field = operand[PARM_MANT-1:0];
   assign exp_zero   = (exp_field == '0);
   assign exp_ones   = &exp_field;
   assign frac_zero  = (frac_field == '0);

   assign cls.sign    = operand[PARM_WIDTH-1];
   assign cls.exp_raw = exp_field;
   // Denormals and zeros share the minimum normal exponent so the aligner sees no gap.
   assign cls.exp_eff = exp_zero ? {{(PARM_EXP-1){1'b0}}, 1'b1} : exp_field;
   assign cls.mant    = {~exp_zero, frac_field};
   assign cls.den     = exp_zero & ~frac_zero;
   assign cls.zero    = exp_zero & frac_zero;
   assign cls.inf     = exp_ones & frac_zero;
   assign cls.nan     = exp_ones & ~frac_zero;
   assign cls.snan    = exp_ones & ~frac_zero & ((frac_field & PARM_MANT_NAN) == '0);

endmodule

// File: rtl/fma_operand_unpacker.sv
// Two-stage valid/ready front end of the MAC: S1 captures raw operands,
// S2 registers the classified fields and the early-invalid decision.
module fma_operand_unpacker
   import fma_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      In_valid_i,
   output logic                      In_ready_o,
   input  logic [PARM_WIDTH-1:0]     A_i,
   input  logic [PARM_WIDTH-1:0]     B_i,
   input  logic [PARM_WIDTH-1:0]     C_i,
   input  logic                      Op_sub_i,
   input  logic [PARM_RM-1:0]        Rounding_mode_i,
   output logic                      Out_valid_o,
   input  logic                      Out_ready_i,
   output logic [2:0]                Sign_o,
   output logic [3*PARM_EXP-1:0]     Exp_raw_o,
   output logic [3*PARM_EXP-1:0]     Exp_eff_o,
   output logic [3*(PARM_MANT+1)-1:0] Mant_o,
   output logic [2:0]                DeN_o,
   output logic [2:0]                Zero_o,
   output logic [2:0]                Inf_o,
   output logic [2:0]                NaN_o,
   output logic [2:0]                SNaN_o,
   output logic                      Sub_Sign_o,
   output logic                      Invalid_early_o,
   output logic [PARM_RM-1:0]        Rounding_mode_o
);

   logic                  s1_valid;
   logic                  s2_valid;
   logic                  s1_adv;
   logic                  s2_adv;
   logic                  accept;

   logic [PARM_WIDTH-1:0] s1_a;
   logic [PARM_WIDTH-1:0] s1_b;
   logic [PARM_WIDTH-1:0] s1_c;
   logic                  s1_op_sub;
   rounding_mode_e        s1_rm;

   fp_class_t             cls_a;
   fp_class_t             cls_b;
   fp_class_t             cls_c;
   logic                  sub_sign;
   logic                  invalid;

   fp_class_t             s2_a;
   fp_class_t             s2_b;
   fp_class_t             s2_c;
   logic                  s2_sub_sign;
   logic                  s2_invalid;
   rounding_mode_e        s2_rm;

   // Backpressure reaches In_ready_o combinationally from Out_ready_i only.
   assign s2_adv     = ~s2_valid | Out_ready_i;
   assign s1_adv     = s1_valid & s2_adv;
   assign In_ready_o = ~s1_valid | s2_adv;
   assign accept     = In_valid_i & In_ready_o;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         // NOTE: datapath registers are reset too, since the outputs must read
         // zero after reset, not merely be qualified by Out_valid_o.
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_c      <= '0;
         s1_op_sub <= 1'b0;
         s1_rm     <= RM_RNE;
      end else begin
         if (In_ready_o) s1_valid <= In_valid_i;
         if (accept) begin
            s1_a      <= A_i;
            s1_b      <= B_i;
            s1_c      <= C_i;
            s1_op_sub <= Op_sub_i;
            s1_rm     <= rounding_mode_e'(Rounding_mode_i);
         end
      end
   end

   fp_classify u_cls_a (.operand(s1_a), .cls(cls_a));
   fp_classify u_cls_b (.operand(s1_b), .cls(cls_b));
   fp_classify u_cls_c (.operand(s1_c), .cls(cls_c));

   // The inf-minus-inf term must stay bit-identical to the Rounder's definition.
   assign sub_sign = cls_a.sign ^ cls_b.sign ^ cls_c.sign ^ s1_op_sub;
   assign invalid  = cls_a.nan | cls_b.nan | cls_c.nan
                   | (cls_b.zero & cls_c.inf)
                   | (cls_c.zero & cls_b.inf)
                   | (sub_sign & cls_a.inf & (cls_b.inf | cls_c.inf));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s2_valid    <= 1'b0;
         s2_a        <= '0;
         s2_b        <= '0;
         s2_c        <= '0;
         s2_sub_sign <= 1'b0;
         s2_invalid  <= 1'b0;
         s2_rm       <= RM_RNE;
      end else begin
         if (s2_adv) s2_valid <= s1_valid;
         if (s1_adv) begin
            s2_a        <= cls_a;
            s2_b        <= cls_b;
            s2_c        <= cls_c;
            s2_sub_sign <= sub_sign;
            s2_invalid  <= invalid;
            s2_rm       <= s1_rm;
         end
      end
   end

   assign Out_valid_o     = s2_valid;
   assign Sign_o          = {s2_a.sign,    s2_b.sign,    s2_c.sign};
   assign Exp_raw_o       = {s2_a.exp_raw, s2_b.exp_raw, s2_c.exp_raw};
   assign Exp_eff_o       = {s2_a.exp_eff, s2_b.exp_eff, s2_c.exp_eff};
   assign Mant_o          = {s2_a.mant,    s2_b.mant,    s2_c.mant};
   assign DeN_o           = {s2_a.den,     s2_b.den,     s2_c.den};
   assign Zero_o          = {s2_a.zero,    s2_b.zero,    s2_c.zero};
   assign Inf_o           = {s2_a.inf,     s2_b.inf,     s2_c.inf};
   assign NaN_o           = {s2_a.nan,     s2_b.nan,     s2_c.nan};
   assign SNaN_o          = {s2_a.snan,    s2_b.snan,    s2_c.snan};
   assign Sub_Sign_o      = s2_sub_sign;
   assign Invalid_early_o = s2_invalid;
   assign Rounding_mode_o = s2_rm;

endmodule

// File: tb/tb_fma_operand_unpacker.sv
// Directed bench for fma_operand_unpacker: field decode, class flags,
// early-invalid terms, backpressure ordering and mid-stream reset.
module tb_fma_operand_unpacker;

   logic        clk_i           = 1'b0;
   logic        rst_ni          = 1'b0;
   logic        In_valid_i      = 1'b0;
   logic        In_ready_o;
   logic [31:0] A_i             = '0;
   logic [31:0] B_i             = '0;
   logic [31:0] C_i             = '0;
   logic        Op_sub_i        = 1'b0;
   logic [2:0]  Rounding_mode_i = '0;
   logic        Out_valid_o;
   logic        Out_ready_i     = 1'b1;
   logic [2:0]  Sign_o;
   logic [23:0] Exp_raw_o;
   logic [23:0] Exp_eff_o;
   logic [71:0] Mant_o;
   logic [2:0]  DeN_o;
   logic [2:0]  Zero_o;
   logic [2:0]  Inf_o;
   logic [2:0]  NaN_o;
   logic [2:0]  SNaN_o;
   logic        Sub_Sign_o;
   logic        Invalid_early_o;
   logic [2:0]  Rounding_mode_o;

   int checks = 0;
   int errors = 0;

   fma_operand_unpacker dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
      .A_i(A_i), .B_i(B_i), .C_i(C_i),
      .Op_sub_i(Op_sub_i), .Rounding_mode_i(Rounding_mode_i),
      .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
      .Sign_o(Sign_o), .Exp_raw_o(Exp_raw_o), .Exp_eff_o(Exp_eff_o),
      .Mant_o(Mant_o), .DeN_o(DeN_o), .Zero_o(Zero_o), .Inf_o(Inf_o),
      .NaN_o(NaN_o), .SNaN_o(SNaN_o), .Sub_Sign_o(Sub_Sign_o),
      .Invalid_early_o(Invalid_early_o), .Rounding_mode_o(Rounding_mode_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present one set with Out_ready high and wait for it at the output;
   // returns at the falling edge where Out_valid_o is observed.
   task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic op, input logic [2:0] rm);
      int n;
      @(negedge clk_i);
      Out_ready_i = 1'b1;
      A_i = a; B_i = b; C_i = c; Op_sub_i = op; Rounding_mode_i = rm;
      In_valid_i = 1'b1;
      #1;
      check({tag, "_in_ready"}, In_ready_o, 1);
      n = 0;
      do begin
         @(negedge clk_i);
         In_valid_i = 1'b0;
         n++;
      end while (!Out_valid_o && n < 8);
      check({tag, "_latency"}, n, 2);
   endtask

   initial begin
      logic [71:0] held_mant;
      logic        was_stalled;
      int          sent;
      int          got;
      int          saw_block;
      int          extra;

      // Reset state
      @(negedge clk_i);
      check("rst_out_valid", Out_valid_o, 0);
      check("rst_mant", Mant_o, 0);
      check("rst_flags", {DeN_o, Zero_o, Inf_o, NaN_o, SNaN_o, Sub_Sign_o, Invalid_early_o}, 0);
      rst_ni = 1'b1;
      #1;
      check("rst_in_ready", In_ready_o, 1);

      // Normal operands: 1.0, 2.0, 3.0
      run_vec("norm", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 3'b011);
      check("norm_mant", Mant_o, {24'h800000, 24'h800000, 24'hC00000});
      check("norm_exp_eff", Exp_eff_o, {8'd127, 8'd128, 8'd128});
      check("norm_exp_raw", Exp_raw_o, {8'd127, 8'd128, 8'd128});
      check("norm_flags", {DeN_o, Zero_o, Inf_o, NaN_o, SNaN_o}, 15'b0);
      check("norm_sign", Sign_o, 3'b000);
      check("norm_sub", Sub_Sign_o, 0);
      check("norm_inv", Invalid_early_o, 0);
      check("norm_rm", Rounding_mode_o, 3'b011);

      // Denormal A, +inf B, zero C: inf*0 is invalid
      run_vec("spec", 32'h00000001, 32'h7F800000, 32'h00000000, 1'b0, 3'b001);
      check("spec_flags", {DeN_o, Zero_o, Inf_o, NaN_o, SNaN_o},
            {3'b100, 3'b001, 3'b010, 3'b000, 3'b000});
      check("spec_exp_eff", Exp_eff_o, {8'd1, 8'hFF, 8'd1});
      check("spec_exp_raw", Exp_raw_o, {8'd0, 8'hFF, 8'd0});
      check("spec_mant", Mant_o, {24'h000001, 24'h800000, 24'h000000});
      check("spec_inv", Invalid_early_o, 1);
      check("spec_rm", Rounding_mode_o, 3'b001);

      // sNaN A, qNaN B
      run_vec("nan", 32'h7FA00000, 32'h7FC00000, 32'h3F800000, 1'b0, 3'b000);
      check("nan_nan", NaN_o, 3'b110);
      check("nan_snan", SNaN_o, 3'b100);
      check("nan_inf", Inf_o, 3'b000);
      check("nan_mant", Mant_o, {24'hA00000, 24'hC00000, 24'h800000});
      check("nan_inv", Invalid_early_o, 1);

      // inf - inf*1
      run_vec("imi_sub", 32'h7F800000, 32'h7F800000, 32'h3F800000, 1'b1, 3'b000);
      check("imi_sub_sign", Sub_Sign_o, 1);
      check("imi_sub_inf", Inf_o, 3'b110);
      check("imi_sub_inv", Invalid_early_o, 1);

      // inf + inf*1 is valid
      run_vec("imi_add", 32'h7F800000, 32'h7F800000, 32'h3F800000, 1'b0, 3'b000);
      check("imi_add_sign", Sub_Sign_o, 0);
      check("imi_add_inv", Invalid_early_o, 0);

      // -inf + inf*1: effective subtraction from the operand sign
      run_vec("neg_inf", 32'hFF800000, 32'h7F800000, 32'h3F800000, 1'b0, 3'b100);
      check("neg_inf_sign", Sign_o, 3'b100);
      check("neg_inf_sub", Sub_Sign_o, 1);
      check("neg_inf_inv", Invalid_early_o, 1);

      // 1 + (-0)*inf: zero*inf with the roles swapped
      run_vec("zinf", 32'h3F800000, 32'h80000000, 32'h7F800000, 1'b0, 3'b010);
      check("zinf_sign", Sign_o, 3'b010);
      check("zinf_zero", Zero_o, 3'b010);
      check("zinf_inf", Inf_o, 3'b001);
      check("zinf_sub", Sub_Sign_o, 1);
      check("zinf_inv", Invalid_early_o, 1);

      // Backpressure: five sets, Out_ready low for cycles 3-6
      sent = 0; got = 0; saw_block = 0; was_stalled = 1'b0; held_mant = '0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         @(negedge clk_i);
         Out_ready_i = !(cyc >= 3 && cyc <= 6);
         In_valid_i  = (sent < 5);
         A_i = {1'b0, 8'(100 + sent), 23'(sent)};
         B_i = 32'h3F800000;
         C_i = 32'h40000000;
         Op_sub_i = 1'b0;
         Rounding_mode_i = 3'b000;
         #1;
         if (was_stalled) begin
            check($sformatf("bp_hold_valid_%0d", cyc), Out_valid_o, 1);
            check($sformatf("bp_hold_mant_%0d", cyc), Mant_o, held_mant);
         end
         if (!In_ready_o) saw_block++;
         if (Out_valid_o && Out_ready_i) begin
            check($sformatf("bp_order_%0d", got), {Exp_raw_o[23:16], Mant_o[71:48]},
                  {8'(100 + got), 1'b1, 23'(got)});
            got++;
         end
         was_stalled = Out_valid_o && !Out_ready_i;
         held_mant   = Mant_o;
         if (In_valid_i && In_ready_o) sent++;
      end
      check("bp_count", got, 5);
      check("bp_blocked", saw_block > 0, 1);
      @(negedge clk_i);
      In_valid_i = 1'b0;
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (Out_valid_o) extra++;
      end
      check("bp_no_dup", extra, 0);

      // Reset with two sets in flight
      @(negedge clk_i);
      Out_ready_i = 1'b0;
      A_i = 32'h3F800000; B_i = 32'h40000000; C_i = 32'h7FC00000;
      Op_sub_i = 1'b1; Rounding_mode_i = 3'b100;
      In_valid_i = 1'b1;
      @(negedge clk_i);
      A_i = 32'h40400000;
      #1;
      check("mid_in_ready", In_ready_o, 1);
      @(negedge clk_i);
      In_valid_i = 1'b0;
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("mid_out_valid", Out_valid_o, 0);
      check("mid_mant", Mant_o, 0);
      check("mid_exp", {Exp_raw_o, Exp_eff_o}, 0);
      check("mid_flags", {Sign_o, DeN_o, Zero_o, Inf_o, NaN_o, SNaN_o, Sub_Sign_o, Invalid_early_o}, 0);
      check("mid_rm", Rounding_mode_o, 0);
      rst_ni = 1'b1;
      Out_ready_i = 1'b1;
      #1;
      check("mid_in_ready_rel", In_ready_o, 1);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         if (Out_valid_o) extra++;
      end
      check("mid_no_ghost", extra, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
